// File: rtl/xm_mem_responder.sv
// Wait-state memory responder: word/byte reads and writes to an internal
// byte-laned RAM with a programmable number of busy cycles per access.
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic            memBusy_o,
  output logic [WORD-1:0] rdata_o,
  output logic            memErr_o
);

  localparam int         LANES     = WORD / 8;
  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  w_accept;
  logic                  w_err_next;
  logic                  r_err;

  logic                  r_rw;
  logic                  r_byte;
  logic                  r_a0;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [WORD-1:0]       r_wdata;

  logic                  r_rd_byte;
  logic                  r_rd_hi;
  logic [WORD-1:0]       w_lanes;

  logic                  w_mis;
  logic                  w_mis_in;
  logic                  w_do_write;
  logic                  w_do_read;

  // A word access on an odd byte address is rejected but keeps normal timing.
  assign w_mis      = !r_byte && r_a0;
  assign w_mis_in   = !byteOp_i && addr_i[0];
  assign w_do_write = (r_state == ACCESS) && !w_mis && r_rw;
  assign w_do_read  = (r_state == ACCESS) && !w_mis && !r_rw;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (memEn_i) begin
          w_accept     = 1'b1;
          w_cnt_next   = WAIT_INIT;
          w_state_next = (WAIT_INIT == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Error flag lands in the ACCESS cycle of a misaligned access, or the
    // cycle after a request that arrived while busy.
    w_err_next = 1'b0;
    if ((r_state != IDLE) && memEn_i) begin
      w_err_next = 1'b1;
    end
    if ((w_state_next == ACCESS) && (r_state != ACCESS)) begin
      if (r_state == IDLE) begin
        if (w_mis_in) begin
          w_err_next = 1'b1;
        end
      end else if (w_mis) begin
        w_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_err     <= 1'b0;
      r_rw      <= 1'b0;
      r_byte    <= 1'b0;
      r_a0      <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rd_byte <= 1'b0;
      r_rd_hi   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_rw    <= memRW_i;
        r_byte  <= byteOp_i;
        r_a0    <= addr_i[0];
        r_idx   <= addr_i[DEPTH_LOG2:1];
        r_wdata <= wdata_i;
      end
      if (w_do_read) begin
        r_rd_byte <= r_byte;
        r_rd_hi   <= r_a0;
      end
    end
  end

  // One RAM per byte lane so byte writes need no read-modify-write.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      logic       w_we;
      logic [7:0] w_wd;

      assign w_we = w_do_write &&
                    (!r_byte || ((gi < 2) && (r_a0 == (gi == 1))));
      assign w_wd = r_byte ? r_wdata[7:0] : r_wdata[8*gi +: 8];

      always_ff @(posedge clk_i) begin
        if (w_we) begin
          r_mem[r_idx] <= w_wd;
        end
      end

      always_ff @(posedge clk_i) begin
        if (arst_i) begin
          r_q <= 8'h00;
        end else if (w_do_read) begin
          r_q <= r_mem[r_idx];
        end
      end

      assign w_lanes[8*gi +: 8] = r_q;
    end
  endgenerate

  always_comb begin
    rdata_o = w_lanes;
    if (r_rd_byte) begin
      rdata_o      = '0;
      rdata_o[7:0] = r_rd_hi ? w_lanes[15:8] : w_lanes[7:0];
    end
  end

  assign memBusy_o = (r_state != IDLE);
  assign memErr_o  = r_err;

endmodule

// File: tb/tb_xm_mem_responder.sv
// Directed bench: one DUT with WAIT_CYCLES=1 (sel 0) and one with
// WAIT_CYCLES=0 (sel 1) sharing clock, reset and request fields.
module tb_xm_mem_responder;

  logic        clk;
  logic        rst;
  logic        en1, en0;
  logic        rw, bop;
  logic [15:0] addr, wdata;
  logic        busy1, err1, busy0, err0;
  logic [15:0] rdata1, rdata0;

  int total = 0;
  int bad   = 0;

  xm_mem_responder #(.WORD(16), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut (
    .clk_i(clk), .arst_i(rst), .memEn_i(en1), .memRW_i(rw), .byteOp_i(bop),
    .addr_i(addr), .wdata_i(wdata), .memBusy_o(busy1), .rdata_o(rdata1),
    .memErr_o(err1)
  );

  xm_mem_responder #(.WORD(16), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .arst_i(rst), .memEn_i(en0), .memRW_i(rw), .byteOp_i(bop),
    .addr_i(addr), .wdata_i(wdata), .memBusy_o(busy0), .rdata_o(rdata0),
    .memErr_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, then count busy cycles and error pulses until idle.
  task automatic run_req(input bit sel, input bit r_w, input bit b,
                         input logic [15:0] a, input logic [15:0] d,
                         output int nbusy, output int nerr);
    rw = r_w; bop = b; addr = a; wdata = d;
    if (sel) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0; en1 = 1'b0;
    nbusy = 0; nerr = 0;
    while ((sel ? busy0 : busy1) && nbusy < 20) begin
      nbusy++;
      if (sel ? err0 : err1) nerr++;
      @(posedge clk); #1;
    end
    if (sel ? err0 : err1) nerr++;
    $display("req dut=%0d rw=%0d byte=%0d addr=%h wdata=%h busy=%0d err=%0d rdata=%h",
             sel, r_w, b, a, d, nbusy, nerr, sel ? rdata0 : rdata1);
  endtask

  task automatic test_reset();
    rst = 1'b1; en1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err1); end
    total++; if (rdata1 !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata1); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    total++; if (rdata0 !== 16'h0000) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0000", rdata0); end
    rst = 1'b0; en1 = 1'b0;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy1); end
  endtask

  task automatic test_word_rw();
    int nb, ne;
    run_req(0, 1, 0, 16'h0010, 16'hBEEF, nb, ne);
    total++; if (nb !== 2) begin bad++; $display("FAIL wr_busy got=%0d exp=2", nb); end
    total++; if (ne !== 0) begin bad++; $display("FAIL wr_err got=%0d exp=0", ne); end
    total++; if (rdata1 !== 16'h0000) begin bad++; $display("FAIL wr_rdata_hold got=%h exp=0000", rdata1); end
    run_req(0, 0, 0, 16'h0010, 16'h0000, nb, ne);
    total++; if (nb !== 2) begin bad++; $display("FAIL rd_busy got=%0d exp=2", nb); end
    total++; if (rdata1 !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=BEEF", rdata1); end
  endtask

  task automatic test_byte_ops();
    int nb, ne;
    run_req(0, 1, 1, 16'h0011, 16'hAB12, nb, ne);
    total++; if (nb !== 2) begin bad++; $display("FAIL bw_busy got=%0d exp=2", nb); end
    run_req(0, 0, 0, 16'h0010, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h12EF) begin bad++; $display("FAIL bw_word_rd got=%h exp=12EF", rdata1); end
    run_req(0, 0, 1, 16'h0010, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h00EF) begin bad++; $display("FAIL br_lo got=%h exp=00EF", rdata1); end
    run_req(0, 0, 1, 16'h0011, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h0012) begin bad++; $display("FAIL br_hi got=%h exp=0012", rdata1); end
  endtask

  task automatic test_misaligned();
    int nb, ne;
    run_req(0, 0, 0, 16'h0003, 16'h0000, nb, ne);
    total++; if (nb !== 2) begin bad++; $display("FAIL mis_busy got=%0d exp=2", nb); end
    total++; if (ne !== 1) begin bad++; $display("FAIL mis_err got=%0d exp=1", ne); end
    total++; if (rdata1 !== 16'h0012) begin bad++; $display("FAIL mis_rdata got=%h exp=0012", rdata1); end
    run_req(0, 1, 0, 16'h0011, 16'hAAAA, nb, ne);
    total++; if (ne !== 1) begin bad++; $display("FAIL mis_wr_err got=%0d exp=1", ne); end
    run_req(0, 0, 0, 16'h0010, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h12EF) begin bad++; $display("FAIL mis_wr_skip got=%h exp=12EF", rdata1); end
  endtask

  task automatic test_busy_collision();
    int nb, ne;
    rw = 1'b1; bop = 1'b0; addr = 16'h0030; wdata = 16'h1234; en1 = 1'b1;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL col_busy got=%b exp=1", busy1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL col_err_early got=%b exp=0", err1); end
    @(posedge clk); #1;
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL col_err got=%b exp=1", err1); end
    en1 = 1'b0;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL col_idle got=%b exp=0", busy1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL col_err_clear got=%b exp=0", err1); end
    $display("req dut=0 rw=1 byte=0 addr=0030 wdata=1234 collision in WAIT");
    run_req(0, 0, 0, 16'h0030, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h1234) begin bad++; $display("FAIL col_data got=%h exp=1234", rdata1); end
  endtask

  task automatic test_back_to_back();
    int nb, ne, n;
    rw = 1'b1; bop = 1'b0; addr = 16'h0032; wdata = 16'h4321; en1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_no_accept got=%b exp=0", busy1); end
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL b2b_err got=%b exp=1", err1); end
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_later_accept got=%b exp=1", busy1); end
    en1 = 1'b0;
    n = 0;
    while (busy1 && n < 20) begin n++; @(posedge clk); #1; end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b exp=0", busy1); end
    $display("req dut=0 rw=1 byte=0 addr=0032 wdata=4321 held enable");
    run_req(0, 0, 0, 16'h0032, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h4321) begin bad++; $display("FAIL b2b_data got=%h exp=4321", rdata1); end
  endtask

  task automatic test_reset_abort();
    int nb, ne;
    run_req(0, 1, 0, 16'h0020, 16'h7777, nb, ne);
    rw = 1'b1; bop = 1'b0; addr = 16'h0020; wdata = 16'h5555; en1 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b exp=1", busy1); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b exp=0", busy1); end
    total++; if (rdata1 !== 16'h0000) begin bad++; $display("FAIL abort_rdata got=%h exp=0000", rdata1); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("req dut=0 rw=1 byte=0 addr=0020 wdata=5555 aborted by reset");
    run_req(0, 0, 0, 16'h0020, 16'h0000, nb, ne);
    total++; if (rdata1 !== 16'h7777) begin bad++; $display("FAIL abort_old got=%h exp=7777", rdata1); end
  endtask

  task automatic test_alias_wait0();
    int nb, ne;
    run_req(1, 1, 0, 16'h0810, 16'hCAFE, nb, ne);
    total++; if (nb !== 1) begin bad++; $display("FAIL w0_wr_busy got=%0d exp=1", nb); end
    run_req(1, 0, 0, 16'h0010, 16'h0000, nb, ne);
    total++; if (nb !== 1) begin bad++; $display("FAIL w0_rd_busy got=%0d exp=1", nb); end
    total++; if (rdata0 !== 16'hCAFE) begin bad++; $display("FAIL w0_alias got=%h exp=CAFE", rdata0); end
    run_req(1, 0, 0, 16'h0013, 16'h0000, nb, ne);
    total++; if (ne !== 1) begin bad++; $display("FAIL w0_mis_err got=%0d exp=1", ne); end
    total++; if (rdata0 !== 16'hCAFE) begin bad++; $display("FAIL w0_mis_rdata got=%h exp=CAFE", rdata0); end
    run_req(1, 1, 1, 16'h0010, 16'h0099, nb, ne);
    run_req(1, 0, 0, 16'h0810, 16'h0000, nb, ne);
    total++; if (rdata0 !== 16'hCA99) begin bad++; $display("FAIL w0_alias_byte got=%h exp=CA99", rdata0); end
  endtask

  initial begin
    rst = 1'b1; en1 = 1'b0; en0 = 1'b0; rw = 1'b0; bop = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_word_rw();
    test_byte_ops();
    test_misaligned();
    test_busy_collision();
    test_back_to_back();
    test_reset_abort();
    test_alias_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
